// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int BCD_DIGIT_W = 4;
   localparam int ADD3_THRESH = 5;

   // Decimal digits needed to show the largest unsigned value of width w.
   function automatic int digits_for_width(input int w);
      logic [127:0] v;
      int           d;
      v = (128'd1 << w) - 128'd1;
      d = 0;
      for (int i = 0; i < 40; i++) begin
         if (v != '0) begin
            v = v / 128'd10;
            d++;
         end
      end
      if (d == 0) d = 1;
      return d;
   endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a digit of 5 or more gets +3 before the shift.
// Purely combinational, no handshake.
module bcd_add3
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] d_in,
   output logic [BCD_DIGIT_W-1:0] d_out
);

   always_comb begin
      d_out = d_in;
      if (d_in >= BCD_DIGIT_W'(ADD3_THRESH)) d_out = d_in + BCD_DIGIT_W'(3);
   end

endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter, one bit per cycle: result WIDTH cycles after accept, held until out_ready.
// Optional leading-zero blank mask under LEADING_ZERO_BLANK_EN; accepts new input only in IDLE.
module bin2bcd_seq
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
)(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WIDTH-1:0]              in_bin,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
   output logic [DIGITS-1:0]             out_blank,
   output logic                          busy
);

   localparam int BCD_W = BCD_DIGIT_W * DIGITS;
   localparam int CNT_W = $clog2(WIDTH + 1);

   if (DIGITS < digits_for_width(WIDTH)) begin : g_digits_check
      $error("bin2bcd_seq: DIGITS too small to hold 2^WIDTH-1");
   end

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [WIDTH-1:0]   bin_shift_q, bin_shift_d;
   logic [BCD_W-1:0]   bcd_work_q, bcd_work_d;
   logic [BCD_W-1:0]   out_bcd_q, out_bcd_d;

   logic [BCD_W-1:0]       corrected;
   logic [BCD_W+WIDTH-1:0] shift_cat;
   logic [BCD_W-1:0]       shift_bcd;
   logic [WIDTH-1:0]       shift_bin;

   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .d_in  (bcd_work_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .d_out (corrected[g*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   always_comb begin
      shift_cat = {corrected, bin_shift_q} << 1;
      shift_bcd = shift_cat[BCD_W+WIDTH-1:WIDTH];
      shift_bin = shift_cat[WIDTH-1:0];
   end

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      bin_shift_d = bin_shift_q;
      bcd_work_d  = bcd_work_q;
      out_bcd_d   = out_bcd_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               bin_shift_d = in_bin;
               bcd_work_d  = '0;
               count_d     = CNT_W'(WIDTH);
               state_d     = SHIFT;
            end
         end
         SHIFT: begin
            bin_shift_d = shift_bin;
            bcd_work_d  = shift_bcd;
            count_d     = count_q - CNT_W'(1);
            if (count_q == CNT_W'(1)) begin
               out_bcd_d = shift_bcd;
               state_d   = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         count_q     <= '0;
         bin_shift_q <= '0;
         bcd_work_q  <= '0;
         out_bcd_q   <= '0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         bin_shift_q <= bin_shift_d;
         bcd_work_q  <= bcd_work_d;
         out_bcd_q   <= out_bcd_d;
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

   logic [DIGITS-1:0] blank_mask;
   logic [DIGITS-1:0] out_blank_q, out_blank_d;

   // Walk down from the most significant digit; digit 0 always stays visible.
   always_comb begin
      logic all_zero;
      all_zero   = 1'b1;
      blank_mask = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         all_zero      = all_zero && (shift_bcd[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
         blank_mask[i] = all_zero;
      end
   end

   always_comb begin
      out_blank_d = out_blank_q;
      if (state_q == SHIFT && count_q == CNT_W'(1)) out_blank_d = blank_mask;
   end

   always_ff @(posedge clk) begin
      if (rst) out_blank_q <= BLANK_RST;
      else     out_blank_q <= out_blank_d;
   end

   assign out_blank = out_blank_q;
`else
   assign out_blank = '0;
`endif

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_bcd   = out_bcd_q;

endmodule
